conv_feed_ctrl: RTL and testbench
=================================

// Module: conv_feed_ctrl
// PURPOSE
//  Transmit side of the conv pixel stream: reads one INPUT_SIZE x INPUT_SIZE feature map
//  from a 1-cycle-latency RAM. Drives it raster-order, gap-free, into the conv unit's
//  input_vld/input_din port, inserting PADDING zero rows/cols on all four sides.
//  After the last pixel it waits for the conv unit's end flag, then reports done.
//  One channel per start; the layer sequencer issues one start per channel via base_addr.
// PARAMETERS
//  N            8     pixel width (bits)
//  INPUT_SIZE   28    unpadded map side; OUT_SIZE = INPUT_SIZE+2*PADDING
//  PADDING      0     zero border width, 0..3
//  AW           12    RAM address width
//  END_TIMEOUT  64    max cycles in WAIT_END before forced finish with error
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   pulse; begin one map transfer (ignored unless IDLE)
//  base_addr    in   AW  RAM address of pixel (0,0); latched on accepted start
//  mem_rd_en    out  1   RAM read strobe
//  mem_rd_addr  out  AW  RAM read address
//  mem_rd_data  in   N   RAM data, valid 1 cycle after mem_rd_en
//  conv_end     in   1   conv unit end flag (level)
//  pix_vld      out  1   to conv input_vld
//  pix_dout     out  N   to conv input_din
//  busy         out  1   high from accepted start until done
//  done         out  1   1-cycle pulse at transfer completion
//  err_timeout  out  1   sticky; set if conv_end not seen in END_TIMEOUT; cleared on start
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 (mem_rd_addr=0, pix_dout=0), counters 0.
//    Reset mid-transfer aborts immediately; no further pix_vld/mem_rd_en.
//  - FSM: IDLE -(start)-> STREAM -(last pos issued)-> DRAIN -(1 cycle)-> WAIT_END
//    -(conv_end=1 or timeout)-> DONE -(1 cycle)-> IDLE.
//  - Position counters row,col in 0..OUT_SIZE-1, col fastest. One position is issued per
//    STREAM cycle; STREAM lasts exactly OUT_SIZE^2 cycles.
//  - Interior position (PADDING<=row,col<PADDING+INPUT_SIZE): mem_rd_en=1,
//    mem_rd_addr = base_addr + (row-PADDING)*INPUT_SIZE + (col-PADDING), wraps mod 2^AW.
//  - Pad position: mem_rd_en=0; an is_pad flag is pipelined alongside.
//  - Output stage is registered 1 cycle after issue:
//    pix_vld = issued_d1; pix_dout = is_pad_d1 ? 0 : mem_rd_data.
//    Start sampled at edge E: first issue at E+1, first pix_vld at E+2.
//    pix_vld is high for exactly OUT_SIZE^2 consecutive cycles with no bubbles.
//  - DRAIN emits the final pix_vld. conv_end is ignored in STREAM/DRAIN (the conv unit
//    holds it high while idle).
//  - WAIT_END: a cycle counter runs. If conv_end=1 is sampled, go to DONE. If the counter
//    reaches END_TIMEOUT, go to DONE and set err_timeout. If conv_end and timeout coincide,
//    conv_end wins and err_timeout is not set.
//  - busy = (state != IDLE). done is high only in DONE.
//  - start while busy: ignored, no side effects. start in the DONE cycle: ignored.
//    start in IDLE the cycle after DONE: accepted.
// TESTING
//  1 INPUT_SIZE=6,PADDING=0,base=0x100, RAM[a]=a&0xFF, conv_end pulse 5 cyc after last ->
//    36 contiguous pix_vld with pix_dout 0x00..0x23 in order; done 1 cyc after conv_end.
//  2 INPUT_SIZE=4,PADDING=1 -> 36 pix_vld; rows 0/5 and cols 0/5 are 0 with mem_rd_en=0;
//    16 reads, addr base..base+15.
//  3 conv_end held 0 after stream, END_TIMEOUT=64 -> done exactly 64 cyc into WAIT_END,
//    err_timeout=1, cleared by next start.
//  4 start pulsed again at 10th pix_vld -> ignored; stream unchanged, single done.
//  5 rst_n=0 at 20th pix_vld for 1 cyc -> next cycle pix_vld=0,busy=0,mem_rd_en=0;
//    new start gives a full clean stream.
//  6 base_addr=2^AW-3 -> addresses wrap to 0 after 2^AW-1; data order preserved.

Source files
------------

// File: rtl/conv_feed_ctrl.sv
// Feature-map feeder for the conv unit: reads one INPUT_SIZE^2 map from a 1-cycle RAM
// and streams it raster-order, gap-free, with a PADDING-wide zero border on all sides.
module conv_feed_ctrl #(
   parameter int N           = 8,
   parameter int INPUT_SIZE  = 28,
   parameter int PADDING     = 0,
   parameter int AW          = 12,
   parameter int END_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [N-1:0]  mem_rd_data,
   input  logic          conv_end,
   output logic          pix_vld,
   output logic [N-1:0]  pix_dout,
   output logic          busy,
   output logic          done,
   output logic          err_timeout
);

   localparam int OUT_SIZE = INPUT_SIZE + 2 * PADDING;
   localparam int CW       = $clog2(OUT_SIZE + 1);
   localparam int TW       = $clog2(END_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_WAIT_END,
      S_DONE
   } state_e;

   state_e          state_q,     state_d;
   logic [CW-1:0]   row_q,       row_d;
   logic [CW-1:0]   col_q,       col_d;
   logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [TW-1:0]   wait_cnt_q,  wait_cnt_d;
   logic            issued_d1_q, issued_d1_d;
   logic            is_pad_d1_q, is_pad_d1_d;
   logic            pix_vld_q,   pix_vld_d;
   logic [N-1:0]    pix_dout_q,  pix_dout_d;
   logic            err_q,       err_d;

   logic            issue;
   logic            interior;
   logic            last_pos;

   // Interior positions are visited in raster order, so their RAM addresses are simply
   // consecutive from base_addr; a running pointer replaces the row*INPUT_SIZE multiply.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      rd_ptr_d    = rd_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      err_d       = err_q;
      issue       = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;

      interior = (int'(row_q) >= PADDING) && (int'(row_q) < PADDING + INPUT_SIZE) &&
                 (int'(col_q) >= PADDING) && (int'(col_q) < PADDING + INPUT_SIZE);
      last_pos = (row_q == CW'(OUT_SIZE - 1)) && (col_q == CW'(OUT_SIZE - 1));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_STREAM;
               rd_ptr_d = base_addr;
               row_d    = '0;
               col_d    = '0;
               err_d    = 1'b0;
            end
         end

         S_STREAM: begin
            issue = 1'b1;
            if (interior) begin
               mem_rd_en   = 1'b1;
               mem_rd_addr = rd_ptr_q;
               rd_ptr_d    = rd_ptr_q + AW'(1);
            end
            if (col_q == CW'(OUT_SIZE - 1)) begin
               col_d = '0;
               row_d = row_q + CW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
            if (last_pos) begin
               state_d = S_DRAIN;
               row_d   = '0;
            end
         end

         S_DRAIN: begin
            state_d    = S_WAIT_END;
            wait_cnt_d = '0;
         end

         // conv_end takes priority over a timeout landing on the same cycle.
         S_WAIT_END: begin
            wait_cnt_d = wait_cnt_q + TW'(1);
            if (conv_end) begin
               state_d = S_DONE;
            end else if (wait_cnt_q == TW'(END_TIMEOUT - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      issued_d1_d = issue;
      is_pad_d1_d = issue && !interior;
      pix_vld_d   = issued_d1_q;
      pix_dout_d  = (issued_d1_q && !is_pad_d1_q) ? mem_rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         rd_ptr_q    <= '0;
         wait_cnt_q  <= '0;
         issued_d1_q <= 1'b0;
         is_pad_d1_q <= 1'b0;
         pix_vld_q   <= 1'b0;
         pix_dout_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         rd_ptr_q    <= rd_ptr_d;
         wait_cnt_q  <= wait_cnt_d;
         issued_d1_q <= issued_d1_d;
         is_pad_d1_q <= is_pad_d1_d;
         pix_vld_q   <= pix_vld_d;
         pix_dout_q  <= pix_dout_d;
         err_q       <= err_d;
      end
   end

   assign pix_vld     = pix_vld_q;
   assign pix_dout    = pix_dout_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Bench for conv_feed_ctrl: an unpadded 6x6 instance and a 4x4/pad-1 instance (both 6x6 out),
// with expected pixels and read addresses queued at start and popped as the DUT produces them.
module tb_conv_feed_ctrl;

   localparam int AW         = 12;
   localparam int N          = 8;
   localparam int OUT        = 6;
   localparam int NPIX       = OUT * OUT;
   localparam int WAIT_START = NPIX + 1;
   localparam int TIMEOUT    = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start;
   logic          conv_end;
   logic          sel;
   logic [AW-1:0] base_addr;

   logic          a_start, a_rd_en, a_pix_vld, a_busy, a_done, a_err;
   logic [AW-1:0] a_rd_addr;
   logic [N-1:0]  a_rd_data = '0;
   logic [N-1:0]  a_pix_dout;
   logic          b_start, b_rd_en, b_pix_vld, b_busy, b_done, b_err;
   logic [AW-1:0] b_rd_addr;
   logic [N-1:0]  b_rd_data = '0;
   logic [N-1:0]  b_pix_dout;

   assign a_start = start & ~sel;
   assign b_start = start & sel;

   conv_feed_ctrl #(.N(N), .INPUT_SIZE(6), .PADDING(0), .AW(AW), .END_TIMEOUT(TIMEOUT)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(base_addr),
      .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
      .conv_end(conv_end), .pix_vld(a_pix_vld), .pix_dout(a_pix_dout),
      .busy(a_busy), .done(a_done), .err_timeout(a_err)
   );

   conv_feed_ctrl #(.N(N), .INPUT_SIZE(4), .PADDING(1), .AW(AW), .END_TIMEOUT(TIMEOUT)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(base_addr),
      .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
      .conv_end(conv_end), .pix_vld(b_pix_vld), .pix_dout(b_pix_dout),
      .busy(b_busy), .done(b_done), .err_timeout(b_err)
   );

   // RAM contents: RAM[a] = a & 0xFF, one-cycle read latency.
   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= a_rd_addr[7:0];
      if (b_rd_en) b_rd_data <= b_rd_addr[7:0];
   end

   wire          rd_en    = sel ? b_rd_en    : a_rd_en;
   wire [AW-1:0] rd_addr  = sel ? b_rd_addr  : a_rd_addr;
   wire          pix_vld  = sel ? b_pix_vld  : a_pix_vld;
   wire [N-1:0]  pix_dout = sel ? b_pix_dout : a_pix_dout;
   wire          busy     = sel ? b_busy     : a_busy;
   wire          done     = sel ? b_done     : a_done;
   wire          err      = sel ? b_err      : a_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0]  exp_pix[$];
   logic [AW-1:0] exp_addr[$];

   function automatic bit is_interior(input bit s, input int r, input int c);
      int in_size;
      int pad;
      in_size = s ? 4 : 6;
      pad     = s ? 1 : 0;
      return (r >= pad) && (r < pad + in_size) && (c >= pad) && (c < pad + in_size);
   endfunction

   task automatic load_scoreboard(input bit s, input logic [AW-1:0] base);
      int in_size;
      int pad;
      logic [AW-1:0] a;
      in_size = s ? 4 : 6;
      pad     = s ? 1 : 0;
      for (int p = 0; p < NPIX; p++) begin
         if (is_interior(s, p / OUT, p % OUT)) begin
            a = base + AW'((p / OUT - pad) * in_size + (p % OUT - pad));
            exp_addr.push_back(a);
            exp_pix.push_back(a[7:0]);
         end else begin
            exp_pix.push_back('0);
         end
      end
   endtask

   // Iteration i is the i-th falling edge after the start was sampled; position i is issued
   // there and pixel i-2 is on the output. end_delay < 0 means conv_end never arrives.
   task automatic run_stream(input bit s, input logic [AW-1:0] base, input int end_delay,
                             input int restart_pix, input bit start_in_done,
                             input int reset_pix, input string tag);
      int            done_iter;
      bit            exp_en;
      bit            exp_vld;
      logic [N-1:0]  ep;
      logic [AW-1:0] ea;
      sel = s;
      exp_pix.delete();
      exp_addr.delete();
      load_scoreboard(s, base);
      done_iter = (end_delay >= 0) ? WAIT_START + end_delay + 1 : WAIT_START + TIMEOUT;
      base_addr = base;
      conv_end  = 1'b1;
      start     = 1'b1;
      for (int i = 0; i <= done_iter; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (reset_pix >= 0 && i == reset_pix + 2) begin
            n_checks++;
            if ({pix_vld, busy, rd_en, done, pix_dout} !== '0) begin
               n_fail++;
               $display("FAIL %s after_reset: vld=%b busy=%b rd_en=%b done=%b dout=%h, need all 0",
                        tag, pix_vld, busy, rd_en, done, pix_dout);
            end
            rst_n = 1'b1;
            exp_pix.delete();
            exp_addr.delete();
            return;
         end
         exp_en = (i < NPIX) && is_interior(s, i / OUT, i % OUT);
         n_checks++;
         if (rd_en !== exp_en) begin
            n_fail++;
            $display("FAIL %s rd_en @%0d: got %b need %b", tag, i, rd_en, exp_en);
         end
         if (rd_en === 1'b1 && exp_en) begin
            n_checks++;
            if (exp_addr.size() == 0) begin
               n_fail++;
               $display("FAIL %s rd_addr @%0d: got %h with no read expected", tag, i, rd_addr);
            end else begin
               ea = exp_addr.pop_front();
               if (rd_addr !== ea) begin
                  n_fail++;
                  $display("FAIL %s rd_addr @%0d: got %h need %h", tag, i, rd_addr, ea);
               end
            end
         end
         exp_vld = (i >= 2) && (i <= NPIX + 1);
         n_checks++;
         if (pix_vld !== exp_vld) begin
            n_fail++;
            $display("FAIL %s pix_vld @%0d: got %b need %b", tag, i, pix_vld, exp_vld);
         end
         if (pix_vld === 1'b1) begin
            n_checks++;
            if (exp_pix.size() == 0) begin
               n_fail++;
               $display("FAIL %s pix_dout @%0d: got %h with no pixel expected", tag, i, pix_dout);
            end else begin
               ep = exp_pix.pop_front();
               if (pix_dout !== ep) begin
                  n_fail++;
                  $display("FAIL %s pix_dout @%0d: got %h need %h", tag, i, pix_dout, ep);
               end
            end
         end
         n_checks++;
         if ({busy, done} !== {1'b1, (i == done_iter)}) begin
            n_fail++;
            $display("FAIL %s busy/done @%0d: got %b%b need 1%b", tag, i, busy, done, (i == done_iter));
         end
         if (i == 0 || i == done_iter) begin
            n_checks++;
            if (err !== (i == done_iter && end_delay < 0)) begin
               n_fail++;
               $display("FAIL %s err_timeout @%0d: got %b need %b", tag, i, err,
                        (i == done_iter && end_delay < 0));
            end
         end
         if (i >= WAIT_START) conv_end = (end_delay >= 0) && (i == WAIT_START + end_delay);
         if (restart_pix >= 0 && i == restart_pix + 1) begin
            start     = 1'b1;
            base_addr = base ^ 12'h0F0;
         end
         if (reset_pix >= 0 && i == reset_pix + 1) rst_n = 1'b0;
         if (start_in_done && i == done_iter) start = 1'b1;
      end
      @(negedge clk);
      start     = 1'b0;
      conv_end  = 1'b1;
      base_addr = base;
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s idle_after_done: got busy=%b done=%b need 00", tag, busy, done);
      end
      n_checks++;
      if (exp_pix.size() != 0 || exp_addr.size() != 0) begin
         n_fail++;
         $display("FAIL %s scoreboard_drained: %0d pixels, %0d addrs left, need 0", tag,
                  exp_pix.size(), exp_addr.size());
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      sel       = 1'b0;
      conv_end  = 1'b1;
      base_addr = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({a_pix_vld, a_busy, a_done, a_err, a_rd_en, a_rd_addr, a_pix_dout} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: vld=%b busy=%b done=%b err=%b rd_en=%b addr=%h dout=%h, need 0",
                  a_pix_vld, a_busy, a_done, a_err, a_rd_en, a_rd_addr, a_pix_dout);
      end
      n_checks++;
      if ({b_pix_vld, b_busy, b_done, b_err, b_rd_en, b_rd_addr, b_pix_dout} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: vld=%b busy=%b done=%b err=%b rd_en=%b addr=%h dout=%h, need 0",
                  b_pix_vld, b_busy, b_done, b_err, b_rd_en, b_rd_addr, b_pix_dout);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({a_busy, b_busy, a_pix_vld, b_pix_vld} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b%b vld=%b%b need 0000", a_busy, b_busy,
                  a_pix_vld, b_pix_vld);
      end
   endtask

   task automatic test_basic();
      run_stream(1'b0, 12'h100, 5, -1, 1'b0, -1, "basic");
   endtask

   task automatic test_padding();
      run_stream(1'b1, 12'h200, 3, -1, 1'b0, -1, "padding");
   endtask

   task automatic test_timeout();
      run_stream(1'b0, 12'h040, -1, -1, 1'b0, -1, "timeout");
      run_stream(1'b0, 12'h300, 0, -1, 1'b0, -1, "err_cleared");
      run_stream(1'b0, 12'h010, TIMEOUT - 1, -1, 1'b0, -1, "end_at_timeout");
   endtask

   task automatic test_back_to_back();
      run_stream(1'b0, 12'h500, 2, 10, 1'b1, -1, "restart_ignored");
      run_stream(1'b0, 12'h600, 1, -1, 1'b0, -1, "back_to_back");
   endtask

   task automatic test_reset_mid();
      run_stream(1'b0, 12'h700, 5, -1, 1'b0, 20, "reset_mid");
      run_stream(1'b0, 12'h700, 5, -1, 1'b0, -1, "post_reset");
   endtask

   task automatic test_wrap();
      run_stream(1'b0, 12'hFFD, 4, -1, 1'b0, -1, "wrap");
      run_stream(1'b1, 12'hFFA, 2, -1, 1'b0, -1, "wrap_pad");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_padding();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
